// File: rtl/seg_scan_pkg.sv
// Glyph codes, segment bit positions and segment patterns for the 7-segment scanner.
// Shared by seg_decode and seg_scan (optional build macro SEG_DIM_EN lives in seg_scan).
package seg_pkg;

  localparam logic [4:0] GL_BLANK = 5'd16;
  localparam logic [4:0] GL_DASH  = 5'd17;
  localparam logic [4:0] GL_L     = 5'd18;
  localparam logic [4:0] GL_P     = 5'd19;
  localparam logic [4:0] GL_H     = 5'd20;
  localparam logic [4:0] GL_N     = 5'd21;
  localparam logic [4:0] GL_O     = 5'd22;
  localparam logic [4:0] GL_R     = 5'd23;
  localparam logic [4:0] GL_U     = 5'd24;
  localparam logic [4:0] GL_Y     = 5'd25;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Patterns carry dp=0; the scanner ORs the decimal point in separately.
  localparam logic [7:0] PAT_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam logic [7:0] PAT_BLANK = 8'h00;
  localparam logic [7:0] PAT_DASH  = 8'h40;
  localparam logic [7:0] PAT_L     = 8'h38;
  localparam logic [7:0] PAT_P     = 8'h73;
  localparam logic [7:0] PAT_H     = 8'h76;
  localparam logic [7:0] PAT_N     = 8'h54;
  localparam logic [7:0] PAT_O     = 8'h5C;
  localparam logic [7:0] PAT_R     = 8'h50;
  localparam logic [7:0] PAT_U     = 8'h3E;
  localparam logic [7:0] PAT_Y     = 8'h6E;

endpackage

// File: rtl/seg_scan_if.sv
// Display bundle between the glyph source (master) and the scanner (slave).
// Level signals, no handshake: the scanner samples the inputs at frame load and drives pins every cycle.
interface seg_scan_if;
  logic [39:0] digits;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic [7:0]  blink;
  logic [2:0]  bright;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out0;
  logic [7:0]  seg_out1;

  modport master (
    output digits, dp, blank, blink, bright,
    input  seg_en, seg_out0, seg_out1
  );

  modport slave (
    input  digits, dp, blank, blink, bright,
    output seg_en, seg_out0, seg_out1
  );
endinterface

// File: rtl/seg_scan_decode.sv
// seg_decode: combinational 5-bit glyph code to 7 segment lines (bit0=a .. bit6=g).
module seg_decode
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  logic [7:0] pat;

  always_comb begin
    pat = PAT_BLANK;
    if (!code[4]) begin
      pat = PAT_HEX[code[3:0]];
    end else begin
      case (code)
        GL_DASH: pat = PAT_DASH;
        GL_L:    pat = PAT_L;
        GL_P:    pat = PAT_P;
        GL_H:    pat = PAT_H;
        GL_N:    pat = PAT_N;
        GL_O:    pat = PAT_O;
        GL_R:    pat = PAT_R;
        GL_U:    pat = PAT_U;
        GL_Y:    pat = PAT_Y;
        default: pat = PAT_BLANK;
      endcase
    end
  end

  assign seg = pat[6:0];

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for eight 7-segment digits, two lit per slot, four slots per frame.
// Build macro SEG_DIM_EN enables the brightness-controlled lit window.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int DEAD_CYC = 16,
  parameter int BLINK_HZ = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int SLOT     = CLK_HZ / SCAN_HZ;
  localparam int DIV_W    = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int BLINK_TC = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLK_W    = (BLINK_TC > 1) ? $clog2(BLINK_TC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOT - 1);
  localparam logic [DIV_W-1:0] DEAD_V   = DIV_W'(DEAD_CYC);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TC - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [BLK_W-1:0] blk_cnt;
  logic             phase;
  logic             load_pend;

  logic [4:0] sh_code [8];
  logic [7:0] sh_dp;
  logic [7:0] sh_blank;
  logic [7:0] sh_blink;

  logic       div_last;
  logic       frame_load;
  logic [2:0] sel0;
  logic [2:0] sel1;
  logic [6:0] raw0;
  logic [6:0] raw1;
  logic       dark0;
  logic       dark1;
  logic       lit;
  logic [7:0] nxt_en;
  logic [7:0] nxt_out0;
  logic [7:0] nxt_out1;

  assign div_last   = (div == DIV_LAST);
  assign frame_load = load_pend || (div_last && (idx == 2'd3));
  assign sel0       = {1'b0, idx};
  assign sel1       = {1'b1, idx};

  seg_decode u_dec0 (.code(sh_code[sel0]), .seg(raw0));
  seg_decode u_dec1 (.code(sh_code[sel1]), .seg(raw1));

  assign dark0 = sh_blank[sel0] | (sh_blink[sel0] & phase);
  assign dark1 = sh_blank[sel1] | (sh_blink[sel1] & phase);

`ifdef SEG_DIM_EN
  localparam int PW = DIV_W + 4;

  logic [2:0]       sh_bright;
  logic [PW-1:0]    win_prod;
  logic [DIV_W:0]   win_len;
  logic [DIV_W:0]   lit_off;

  // Lit window length = ((SLOT-DEAD)*(bright+1))>>3; the product fits in PW bits.
  assign win_prod = PW'(SLOT - DEAD_CYC) * PW'({1'b0, sh_bright} + 4'd1);
  assign win_len  = win_prod[PW-1:3];
  assign lit_off  = {1'b0, div - DEAD_V};
  assign lit      = (div >= DEAD_V) && (lit_off < win_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bright <= 3'd7;
    end else if (frame_load) begin
      sh_bright <= bus.bright;
    end
  end
`else
  logic unused_bright;

  assign unused_bright = ^bus.bright;
  assign lit           = (div >= DEAD_V);
`endif

  always_comb begin
    nxt_en   = '0;
    nxt_out0 = '0;
    nxt_out1 = '0;
    if (lit) begin
      nxt_en[sel0] = 1'b1;
      nxt_en[sel1] = 1'b1;
    end
    if (!dark0) begin
      nxt_out0[6:0]    = raw0;
      nxt_out0[SEG_DP] = sh_dp[sel0];
    end
    if (!dark1) begin
      nxt_out1[6:0]    = raw1;
      nxt_out1[SEG_DP] = sh_dp[sel1];
    end
  end

  // Slot timing: div walks the slot, idx steps once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div_last) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Blink phase runs freely, unrelated to the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (blk_cnt == BLK_LAST) begin
      blk_cnt <= '0;
      phase   <= ~phase;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  // Shadow copy updates only at frame boundaries so a frame never mixes old and new glyphs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pend <= 1'b1;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_blink  <= '0;
      for (int i = 0; i < 8; i++) begin
        sh_code[i] <= GL_BLANK;
      end
    end else begin
      load_pend <= 1'b0;
      if (frame_load) begin
        sh_dp    <= bus.dp;
        sh_blank <= bus.blank;
        sh_blink <= bus.blink;
        for (int i = 0; i < 8; i++) begin
          sh_code[i] <= bus.digits[5*i +: 5];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_en   <= '0;
      bus.seg_out0 <= '0;
      bus.seg_out1 <= '0;
    end else begin
      bus.seg_en   <= nxt_en;
      bus.seg_out0 <= nxt_out0;
      bus.seg_out1 <= nxt_out1;
    end
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed driver for the board's eight 7-segment digits.
- Sits directly downstream of sig_sel. The mode/song/note display logic hands it eight 5-bit glyph codes plus per-digit decimal-point, blank and blink flags.
- It drives seg_en, seg_out0 (digits 0-3) and seg_out1 (digits 4-7) to the pins.
- Two digits are lit per slot (one per segment bus); four slots make one frame.

Parameters:
- CLK_HZ, 100000000: input clock frequency.
- SCAN_HZ, 1000: slot rate. SLOT = CLK_HZ/SCAN_HZ cycles per slot.
- DEAD_CYC, 16: cycles at the start of each slot with seg_en forced low (anti-ghosting). Must be < SLOT.
- BLINK_HZ, 2: blink rate. Phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digits  in  40  glyph codes; digit i = digits[5i+4:5i], digit 0 leftmost
- dp  in  8  decimal point per digit, 1 = lit
- blank  in  8  1 = digit dark
- blink  in  8  1 = digit dark while blink phase = 1
- bright  in  3  brightness level; used only with SEG_DIM_EN
- seg_en  out  8  digit enables, active high
- seg_out0  out  8  segments for digits 0-3: bit0=a … bit6=g, bit7=dp, active high
- seg_out1  out  8  segments for digits 4-7, same encoding

Behaviour:
- Reset (async, rst_n=0):
  - seg_en=0, seg_out0=0, seg_out1=0.
  - slot counter div=0, slot index idx=0, blink counter=0, phase=0.
  - Shadow registers: all codes=16 (blank), dp/blank/blink=0.
  - Reset mid-slot takes effect immediately. Scanning restarts at idx 0 after release.
- Slot counter: div counts 0..SLOT-1. At div==SLOT-1, div->0 and idx->(idx+1) mod 4.
- Frame load:
  - Shadow registers load digits/dp/blank/blink on the cycle idx wraps 3->0, and on the first cycle after reset release.
  - Input changes mid-frame are not shown until the next frame, so there is no tearing.
- Outputs are registered, one cycle after div/idx:
  - seg_en[idx] and seg_en[idx+4] = 1 iff div >= DEAD_CYC.
  - All other seg_en bits = 0.
  - seg_out0 = decode(shadow digit idx); seg_out1 = decode(shadow digit idx+4).
- Per-digit suppression: if blank, or (blink and phase), the segments are 0, including dp. Otherwise bit7 = dp.
- Glyph codes:
  - 0-15: hex 0-F.
  - 16: blank.
  - 17: '-' (g only).
  - 18: L, 19: P, 20: H, 21: n, 22: o, 23: r, 24: U, 25: y.
  - 26-31: blank.
- Blink counter: free-running, independent of the frame. Phase toggles at terminal count; the counter wraps to 0.
- Counter widths use $clog2 of the respective terminal counts. No overflow is possible.

Optional Feature:
- Macro: SEG_DIM_EN.
- When defined:
  - Within each slot, seg_en stays high only while div - DEAD_CYC < ((SLOT-DEAD_CYC)*(bright+1))>>3. bright=7 gives the full lit window.
  - bright is sampled at frame load.
- When undefined: bright is ignored and the full lit window always applies.

Decomposition:
- seg_pkg:
  - Glyph code constants (GL_BLANK=16, GL_DASH=17, GL_L…GL_Y).
  - Segment bit positions.
  - An 8-bit pattern constant per glyph.
- One sub-module, seg_decode: combinational 5-bit code -> 7-bit segments. Instantiated twice (bus 0 and bus 1).
- seg_scan holds all sequential logic.

Test Plan:
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (SLOT=10), DEAD_CYC=2, BLINK_HZ=25 (toggle every 20 cycles).
1. Reset held, then released with digits={8{5'd8}}: seg_en stays 0 until the first registered cycle with div>=2. It then cycles 8'h11, 8'h22, 8'h44, 8'h88, each for 8 of 10 cycles. seg_out0 = seg_out1 = 8'h7F during lit cycles.
2. Digit 0 = 5'd1, digit 4 = 5'd17, dp[0]=1: in slot 0, seg_out0=8'h86 and seg_out1=8'h40.
3. Change digits mid-frame (idx=1): outputs keep the old codes through idx 3. The new codes appear starting at the next idx 0 slot.
4. blink=8'h01, digit 0 = 5'd0: seg_out0 in slot 0 alternates 8'h3F / 8'h00 with a 20-cycle phase. Other digits are unaffected.
5. blank=8'hFF: seg_out0/1 = 0 while seg_en still scans. Assert rst_n=0 mid-slot: all outputs go 0 asynchronously.
6. With SEG_DIM_EN and bright=3: lit window = 4 cycles per slot (div 2..5). With bright=7: 8 cycles.
